// File: rtl/pid_pkg.sv
// pid_pkg: shared FSM encoding, pid_select bit positions and widths for pid_controller and pid_tuner
package pid_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int GAIN_W = DATA_WIDTH / 2;
  localparam int SEL_P = 2;
  localparam int SEL_I = 1;
  localparam int SEL_D = 0;
  typedef enum logic [2:0] {IDLE, ERR, PTERM, ITERM, DTERM, SUM} state_t;
endpackage

// File: rtl/pid_if.sv
// pid_if: controller bus (pid_select, setpoint_period, period_speed, sample_valid, Kp/Ki/Kd in; duty, duty_valid, busy, overrun out)
interface pid_if import pid_pkg::*; #(parameter int DW = DATA_WIDTH);
  localparam int GW = DW / 2;
  logic [2:0] pid_select;
  logic [DW-1:0] setpoint_period;
  logic [DW-1:0] period_speed;
  logic sample_valid;
  logic [GW-1:0] Kp;
  logic [GW-1:0] Ki;
  logic [GW-1:0] Kd;
  logic [DW-1:0] duty;
  logic duty_valid;
  logic busy;
  logic overrun;
  modport master(output pid_select, setpoint_period, period_speed, sample_valid, Kp, Ki, Kd,
                 input duty, duty_valid, busy, overrun);
  modport slave(input pid_select, setpoint_period, period_speed, sample_valid, Kp, Ki, Kd,
                output duty, duty_valid, busy, overrun);
endinterface

// File: rtl/pid_controller_sat_clamp.sv
// sat_clamp: signed saturation of din (IN_W) into [lo, hi] (OUT_W), IN_W >= OUT_W
module sat_clamp #(parameter int IN_W = 33, parameter int OUT_W = 32) (
  input  logic signed [IN_W-1:0]  din,
  input  logic signed [OUT_W-1:0] lo,
  input  logic signed [OUT_W-1:0] hi,
  output logic signed [OUT_W-1:0] dout
);
  always_comb dout = (din < IN_W'(lo)) ? lo : (din > IN_W'(hi)) ? hi : din[OUT_W-1:0];
endmodule

// File: rtl/pid_controller.sv
// pid_controller: multi-cycle PID speed loop, one shared 18x9 multiplier; ports clk, reset (async, high), bus (pid_if.slave)
// Sample accepted in IDLE, then ERR/PTERM/ITERM/DTERM/SUM one per cycle; duty_valid lands 6 clocks after the strobe.
module pid_controller import pid_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 4,
  parameter int INT_LIMIT  = 1048576,
  parameter int DUTY_MAX   = 2499
) (
  input logic clk,
  input logic reset,
  pid_if.slave bus
);
  localparam int GW = DATA_WIDTH / 2;
  localparam int EW = DATA_WIDTH + 1;
  localparam int PW = EW + GW + 1;
  localparam int MW = EW + GW + 2;
  state_t state;
  logic [2:0] sel;
  logic [DATA_WIDTH-1:0] per, sp, duty;
  logic [GW-1:0] kp, ki, kd;
  logic signed [EW-1:0] e, e_prev;
  logic signed [PW-1:0] p_term;
  logic signed [31:0] integ, integ_c;
  logic signed [MW-1:0] d_term, prod;
  logic signed [EW:0] diff, mul_a;
  logic signed [GW:0] mul_b;
  logic signed [32:0] i_sum;
  logic signed [33:0] s;
  logic signed [DATA_WIDTH-1:0] duty_c;
  logic duty_valid, busy, overrun;
  always_comb begin
    diff = e - e_prev;
    mul_a = (state == DTERM) ? diff : {e[EW-1], e};
    mul_b = $signed({1'b0, (state == PTERM) ? kp : (state == ITERM) ? ki : kd});
    prod = mul_a * mul_b;
    i_sum = 33'(integ) + 33'(prod);
    s = (34'(p_term) + 34'(integ) + 34'(d_term)) >>> FRAC_BITS;
  end
  sat_clamp #(.IN_W(33), .OUT_W(32)) u_int_clamp (
    .din(i_sum), .lo(32'(-INT_LIMIT)), .hi(32'(INT_LIMIT)), .dout(integ_c)
  );
  sat_clamp #(.IN_W(34), .OUT_W(DATA_WIDTH)) u_duty_clamp (
    .din(s), .lo('0), .hi(DATA_WIDTH'(DUTY_MAX)), .dout(duty_c)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel <= '0;
      per <= '0;
      sp <= '0;
      kp <= '0;
      ki <= '0;
      kd <= '0;
      e <= '0;
      e_prev <= '0;
      p_term <= '0;
      integ <= '0;
      d_term <= '0;
      duty <= '0;
      duty_valid <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      // busy stays up through the cycle where duty_valid is presented
      busy <= bus.sample_valid || state != IDLE;
      overrun <= bus.sample_valid && state != IDLE;
      case (state)
        IDLE: if (bus.sample_valid) begin
          sel <= bus.pid_select;
          per <= bus.period_speed;
          sp <= bus.setpoint_period;
          kp <= bus.Kp;
          ki <= bus.Ki;
          kd <= bus.Kd;
          state <= ERR;
        end
        ERR: begin
          e <= $signed({1'b0, per}) - $signed({1'b0, sp});
          state <= PTERM;
        end
        PTERM: begin
          p_term <= sel[SEL_P] ? PW'(prod) : '0;
          state <= ITERM;
        end
        ITERM: begin
          // disabled integrator is held at zero so re-enabling starts clean
          integ <= sel[SEL_I] ? integ_c : '0;
          state <= DTERM;
        end
        DTERM: begin
          d_term <= sel[SEL_D] ? prod : '0;
          e_prev <= e;
          state <= SUM;
        end
        SUM: begin
          duty <= duty_c;
          duty_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.duty = duty;
  assign bus.duty_valid = duty_valid;
  assign bus.busy = busy;
  assign bus.overrun = overrun;
endmodule
